// File: rtl/ariane_pkg.sv
// ============================================================================
// Module      : ariane_pkg (package)
// Description : Control-flow and branch-prediction types exchanged between
//               the execute stage and the frontend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_pkg;

    // Kind of control-flow instruction that was resolved.
    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    // Resolution record issued by the execute stage.
    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target_address;
        logic                   is_mispredict;
        logic                   is_taken;
        cf_t                    cf_type;
    } bp_resolve_t;

    // Direction prediction handed to the frontend.
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    // One branch history table entry.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_entry_t;

endpackage : ariane_pkg

`default_nettype wire

// File: rtl/bht_update_unit_pkg.sv
// ============================================================================
// Module      : bht_update_unit_pkg (package)
// Description : State encoding, entry init value and resolve filter for the
//               branch history table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bht_update_unit_pkg;

    import ariane_pkg::*;

    // Two-state controller: sweeping the table, or serving lookups/updates.
    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    // Swept entries start weakly not-taken so one taken outcome flips them.
    localparam logic [1:0] c_ctr_init = 2'b01;

    // Only conditional branches train the direction counters.
    function automatic logic is_branch_resolve(input bp_resolve_t res);
        return res.valid && (res.cf_type == Branch);
    endfunction

endpackage : bht_update_unit_pkg

`default_nettype wire

// File: rtl/riscv.sv
// ============================================================================
// Module      : riscv (package)
// Description : Minimal architectural constants shared by the frontend blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv;

    // Virtual address width of fetch and branch PCs.
    localparam int unsigned VLEN = 64;

endpackage : riscv

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : Combinational 2-bit saturating up/down counter step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2 (
    input  logic [1:0] ctr_i,
    input  logic       up_i,
    output logic [1:0] ctr_o
);

    // Step one towards 11 when counting up, towards 00 otherwise; hold at the rails.
    always_comb begin
        ctr_o = ctr_i;
        if (up_i) begin
            if (ctr_i != 2'b11) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != 2'b00) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule : sat_counter2

`default_nettype wire

// File: rtl/bht_update_unit.sv
// ============================================================================
// Module      : bht_update_unit
// Description : Untagged branch history table. A sequential sweep clears it
//               after reset and flush; resolved conditional branches train
//               2-bit counters; lookups return a registered prediction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_update_unit #(
    parameter int unsigned NR_ENTRIES = 64,
    parameter int unsigned INDEX_LSB  = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_bp_i,
    input  logic                        debug_mode_i,
    input  logic [riscv::VLEN-1:0]      vpc_i,
    input  logic                        lookup_valid_i,
    input  ariane_pkg::bp_resolve_t     resolved_branch_i,
    output ariane_pkg::bht_prediction_t bht_prediction_o,
    output logic                        init_done_o
);

    import ariane_pkg::*;
    import bht_update_unit_pkg::*;

    localparam int unsigned             c_idx_w    = $clog2(NR_ENTRIES);
    localparam logic [c_idx_w-1:0]      c_last_idx = c_idx_w'(NR_ENTRIES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         r_state_q,    r_state_d;
    logic [c_idx_w-1:0] r_init_idx_q, r_init_idx_d;
    bht_prediction_t    r_pred_q,     r_pred_d;
    bht_entry_t         r_table_q [NR_ENTRIES];

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic               w_run;
    logic               w_sweep_en;
    logic               w_upd_en;
    logic               w_wr_en;
    logic [c_idx_w-1:0] w_lookup_idx;
    logic [c_idx_w-1:0] w_upd_idx;
    logic [c_idx_w-1:0] w_wr_idx;
    bht_entry_t         w_lookup_entry;
    bht_entry_t         w_upd_entry;
    bht_entry_t         w_wr_data;
    logic [1:0]         w_upd_ctr;
    logic               w_unused_bits;

    assign w_run        = (r_state_q == c_st_run);
    assign w_lookup_idx = vpc_i[INDEX_LSB +: c_idx_w];
    assign w_upd_idx    = resolved_branch_i.pc[INDEX_LSB +: c_idx_w];

    // Both read ports see the table as it stood before this cycle's write,
    // so a same-cycle lookup and update to one index returns the old value.
    assign w_lookup_entry = r_table_q[w_lookup_idx];
    assign w_upd_entry    = r_table_q[w_upd_idx];

    // Training is only accepted in RUN; a concurrent flush discards it.
    assign w_upd_en = w_run && !flush_bp_i && !debug_mode_i
                      && is_branch_resolve(resolved_branch_i);

    sat_counter2 u_sat_counter2 (
        .ctr_i (w_upd_entry.ctr),
        .up_i  (resolved_branch_i.is_taken),
        .ctr_o (w_upd_ctr)
    );

    // Single write port: the sweep takes precedence over training.
    assign w_wr_en  = !rst_i && (w_sweep_en || w_upd_en);
    assign w_wr_idx = w_sweep_en ? r_init_idx_q : w_upd_idx;

    // Select the entry image written through the single table port.
    always_comb begin
        w_wr_data = '0;
        if (w_sweep_en) begin
            w_wr_data.valid = 1'b0;
            w_wr_data.ctr   = c_ctr_init;
        end else begin
            w_wr_data.valid = 1'b1;
            w_wr_data.ctr   = w_upd_ctr;
        end
    end

    // Next-state logic for the sweep controller; a flush restarts the sweep.
    always_comb begin
        r_state_d    = r_state_q;
        r_init_idx_d = r_init_idx_q;
        w_sweep_en   = 1'b0;
        if (flush_bp_i) begin
            r_state_d    = c_st_init;
            r_init_idx_d = '0;
        end else if (r_state_q == c_st_init) begin
            w_sweep_en = 1'b1;
            if (r_init_idx_q == c_last_idx) begin
                r_state_d = c_st_run;
            end else begin
                r_init_idx_d = r_init_idx_q + c_idx_w'(1);
            end
        end
    end

    // Registered lookup result; cleared whenever the table is not serving.
    always_comb begin
        r_pred_d = '0;
        if (lookup_valid_i && w_run && !flush_bp_i) begin
            r_pred_d.valid = w_lookup_entry.valid;
            r_pred_d.taken = w_lookup_entry.ctr[1];
        end
    end

    // Controller and prediction registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= c_st_init;
            r_init_idx_q <= '0;
            r_pred_q     <= '0;
        end else begin
            r_state_q    <= r_state_d;
            r_init_idx_q <= r_init_idx_d;
            r_pred_q     <= r_pred_d;
        end
    end

    // Table storage; contents are meaningless until the sweep has passed.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_table_q[w_wr_idx] <= w_wr_data;
        end
    end

    assign bht_prediction_o = r_pred_q;
    assign init_done_o      = w_run;

    // Upper PC bits, target address and mispredict flag do not affect the table.
    assign w_unused_bits = ^{vpc_i, resolved_branch_i};

endmodule : bht_update_unit

`default_nettype wire

// File: tb/tb_bht_update_unit.sv
// ============================================================================
// Module      : tb_bht_update_unit
// Description : Self-checking bench for bht_update_unit: directed vectors,
//               hand sequences for sweep/flush/reset, randomized traffic
//               against a behavioural table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bht_update_unit;

    import ariane_pkg::*;

    localparam int unsigned N = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   dbg;
    logic                   lk;
    logic [riscv::VLEN-1:0] vpc;
    bp_resolve_t            rb;
    bht_prediction_t        pred;
    logic                   done;

    always #5 clk = ~clk;

    bht_update_unit #(
        .NR_ENTRIES (N),
        .INDEX_LSB  (1)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_bp_i        (flush),
        .debug_mode_i      (dbg),
        .vpc_i             (vpc),
        .lookup_valid_i    (lk),
        .resolved_branch_i (rb),
        .bht_prediction_o  (pred),
        .init_done_o       (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: counters as integers 0..3, a sweep position, a run flag.
    int m_ctr   [N];
    bit m_valid [N];
    bit m_run   = 1'b0;
    int m_sweep = 0;
    bit m_pv    = 1'b0;
    bit m_pt    = 1'b0;

    function automatic int idx_of(input logic [riscv::VLEN-1:0] pc);
        return int'((pc >> 1) % N);
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: {valid,taken,done} got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        int li, ui;
        if (rst || flush) begin
            m_run = 1'b0; m_sweep = 0; m_pv = 1'b0; m_pt = 1'b0;
        end else if (!m_run) begin
            m_valid[m_sweep] = 1'b0;
            m_ctr[m_sweep]   = 1;
            m_sweep++;
            if (m_sweep == N) m_run = 1'b1;
            m_pv = 1'b0; m_pt = 1'b0;
        end else begin
            li   = idx_of(vpc);
            m_pv = lk ? m_valid[li] : 1'b0;
            m_pt = lk ? (m_ctr[li] >= 2) : 1'b0;
            if (rb.valid && rb.cf_type == Branch && !dbg) begin
                ui = idx_of(rb.pc);
                if (rb.is_taken) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                else             m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                m_valid[ui] = 1'b1;
            end
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", {pred.valid, pred.taken, done}, {m_pv, m_pt, m_run});
    endtask

    task automatic idle();
        flush = 1'b0; dbg = 1'b0; lk = 1'b0; vpc = '0; rb = '0;
    endtask

    task automatic set_upd(input logic [63:0] pc, input cf_t cf, input logic tk);
        rb.valid         = 1'b1;
        rb.pc            = pc;
        rb.target_address = 64'($urandom);
        rb.is_mispredict = 1'($urandom);
        rb.cf_type       = cf;
        rb.is_taken      = tk;
    endtask

    typedef struct {
        string       name;
        logic        dbg;
        logic        lk;
        logic [63:0] vpc;
        logic        uv;
        logic [63:0] upc;
        cf_t         cf;
        logic        tk;
        logic        ev;
        logic        et;
    } vec_t;

    function automatic vec_t mk(input string name, input logic d, input logic l, input logic [63:0] v,
                                input logic u, input logic [63:0] p, input cf_t c, input logic t,
                                input logic ev, input logic et);
        vec_t r;
        r.name = name; r.dbg = d; r.lk = l; r.vpc = v; r.uv = u; r.upc = p;
        r.cf = c; r.tk = t; r.ev = ev; r.et = et;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        // PCs: A -> index 8, B -> 16, C -> 24, D aliases A (index 8).
        logic [63:0] pa, pb, pc_c, pd;
        pa = 64'h8000_0010; pb = 64'h8000_0020; pc_c = 64'h8000_0030; pd = 64'h8000_0090;

        vecs.push_back(mk("tk1",        0, 0, 0,    1, pa,   Branch, 1, 0, 0));
        vecs.push_back(mk("tk2",        0, 0, 0,    1, pa,   Branch, 1, 0, 0));
        vecs.push_back(mk("lk_11",      0, 1, pa,   0, 0,    Branch, 0, 1, 1));
        vecs.push_back(mk("nt1_oldval", 0, 1, pa,   1, pa,   Branch, 0, 1, 1));
        vecs.push_back(mk("nt2_oldval", 0, 1, pa,   1, pa,   Branch, 0, 1, 1));
        vecs.push_back(mk("lk_01",      0, 1, pa,   0, 0,    Branch, 0, 1, 0));
        vecs.push_back(mk("nt3",        0, 0, 0,    1, pa,   Branch, 0, 0, 0));
        vecs.push_back(mk("nt4",        0, 0, 0,    1, pa,   Branch, 0, 0, 0));
        vecs.push_back(mk("nt5",        0, 0, 0,    1, pa,   Branch, 0, 0, 0));
        vecs.push_back(mk("lk_00",      0, 1, pa,   0, 0,    Branch, 0, 1, 0));
        // From 00 one taken step reaches 01, still predicting not-taken.
        vecs.push_back(mk("tk_from00",  0, 1, pa,   1, pa,   Branch, 1, 1, 0));
        vecs.push_back(mk("lk_sat_low", 0, 1, pa,   0, 0,    Branch, 0, 1, 0));
        vecs.push_back(mk("same_cyc",   0, 1, pb,   1, pb,   Branch, 1, 0, 0));
        // Counter 01 -> 10, whose MSB predicts taken.
        vecs.push_back(mk("next_cyc",   0, 1, pb,   0, 0,    Branch, 0, 1, 1));
        vecs.push_back(mk("jumpr",      0, 0, 0,    1, pc_c, JumpR,  1, 0, 0));
        vecs.push_back(mk("debug",      1, 0, 0,    1, pc_c, Branch, 1, 0, 0));
        vecs.push_back(mk("lk_nochg",   0, 1, pc_c, 0, 0,    Branch, 0, 0, 0));
        vecs.push_back(mk("alias",      0, 1, pd,   0, 0,    Branch, 0, 1, 0));
        vecs.push_back(mk("novalid",    0, 0, 0,    0, pc_c, Branch, 1, 0, 0));
        vecs.push_back(mk("lk_nochg2",  0, 1, pc_c, 0, 0,    Branch, 0, 0, 0));

        // Reset state.
        rst = 1'b1; idle();
        tick();
        tick();
        check("reset", {pred.valid, pred.taken, done}, 3'b000);

        // Initial sweep with a lookup held on 0x80000000.
        rst = 1'b0; lk = 1'b1; vpc = 64'h8000_0000;
        for (int k = 1; k <= N; k++) begin
            tick();
            check("sweep", {pred.valid, pred.taken, done}, {2'b00, 1'(k == N)});
        end
        tick();
        check("first_run_lookup", {pred.valid, pred.taken, done}, 3'b001);

        // Directed vector table.
        foreach (vecs[i]) begin
            idle();
            dbg = vecs[i].dbg; lk = vecs[i].lk; vpc = vecs[i].vpc;
            if (vecs[i].uv) set_upd(vecs[i].upc, vecs[i].cf, vecs[i].tk);
            else begin rb.pc = vecs[i].upc; rb.cf_type = vecs[i].cf; rb.is_taken = vecs[i].tk; end
            tick();
            check(vecs[i].name, {pred.valid, pred.taken, done}, {vecs[i].ev, vecs[i].et, 1'b1});
        end

        // Populate, then flush together with an update and a lookup.
        idle(); set_upd(64'h8000_0040, Branch, 1); tick();
        idle(); set_upd(64'h8000_0042, Branch, 1); tick();
        idle(); lk = 1'b1; vpc = 64'h8000_0040; tick();
        check("populated", {pred.valid, pred.taken, done}, 3'b111);
        flush = 1'b1; set_upd(64'h8000_0044, Branch, 1); tick();
        check("flush_edge", {pred.valid, pred.taken, done}, 3'b000);
        idle(); lk = 1'b1; vpc = 64'h8000_0040;
        for (int k = 1; k <= N; k++) begin
            tick();
            check("flush_sweep", {pred.valid, pred.taken, done}, {2'b00, 1'(k == N)});
        end
        for (int j = 0; j < 3; j++) begin
            vpc = 64'h8000_0040 + 64'(2 * j);
            tick();
            check("after_flush", {pred.valid, pred.taken, done}, 3'b001);
        end

        // Reset mid-sweep at init index 20; full sweep needed again.
        idle(); flush = 1'b1; tick();
        flush = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        rst = 1'b1; lk = 1'b1; tick();
        check("reset_mid_sweep", {pred.valid, pred.taken, done}, 3'b000);
        rst = 1'b0;
        for (int k = 1; k <= N; k++) begin
            tick();
            check("resweep", {pred.valid, pred.taken, done}, {2'b00, 1'(k == N)});
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] base;
            idle();
            rst   = ($urandom_range(0, 399) == 0);
            flush = ($urandom_range(0, 149) == 0);
            dbg   = ($urandom_range(0, 9) == 0);
            lk    = 1'($urandom);
            base  = (64'($urandom) << 7) | 64'($urandom_range(0, 1));
            vpc   = base | (64'($urandom_range(0, 7)) << 1);
            if ($urandom_range(0, 1) == 1)
                set_upd(base | (64'($urandom_range(0, 7)) << 1), cf_t'($urandom_range(0, 4)), 1'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bht_update_unit

`default_nettype wire
